// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder for filtered encoder phases A/B.
// Keeps a wrapping signed position count, a saturating per-window speed
// measurement, the direction of the last legal step and a sticky error
// flag for transitions in which both phases changed at once.
module quad_decoder #(
  parameter int CLK_Freq    = 50000000,
  parameter int SAMPLE_Freq = 100,
  parameter int POS_W       = 32,
  parameter int VEL_W       = 16
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iDATA_A,
  input  logic             iDATA_B,
  input  logic             iPOS_CLR,
  input  logic             iERR_CLR,
  output logic [POS_W-1:0] oPOSITION,
  output logic [VEL_W-1:0] oSPEED,
  output logic             oSPEED_VALID,
  output logic             oDIR,
  output logic             oERR
);

  localparam int WIN_N = CLK_Freq / SAMPLE_Freq;
  localparam int WIN_W = (WIN_N > 1) ? $clog2(WIN_N) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_N - 1);
  localparam logic signed [VEL_W:0] VEL_MAX = {2'b00, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W:0] VEL_MIN = {2'b11, {(VEL_W-1){1'b0}}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [1:0]              init_cnt;
  logic [1:0]              init_cnt_nxt;
  logic                    a_meta;
  logic                    a_sync;
  logic                    b_meta;
  logic                    b_sync;
  logic [1:0]              cur;
  logic [1:0]              prev;
  logic signed [1:0]       step;
  logic                    bad;
  logic [POS_W-1:0]        step_pos;
  logic signed [VEL_W:0]   step_vel;
  logic signed [VEL_W:0]   acc_sum;
  logic [VEL_W-1:0]        acc_sat;
  logic [VEL_W-1:0]        acc;
  logic [WIN_W-1:0]        win_cnt;

  assign cur = {a_sync, b_sync};

  // Two-flop synchronisers for both phases, plus the previous synchronised state
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      a_meta <= 1'b0;
      a_sync <= 1'b0;
      b_meta <= 1'b0;
      b_sync <= 1'b0;
      prev   <= 2'b00;
    end else begin
      a_meta <= iDATA_A;
      a_sync <= a_meta;
      b_meta <= iDATA_B;
      b_sync <= b_meta;
      prev   <= cur;
    end
  end

  // State register for the start-up sequencer
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_INIT;
      init_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Hold off decoding until the synchronisers hold real input and prev has been loaded from them
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      ST_INIT: begin
        if (init_cnt == 2'd2) begin
          state_nxt = ST_RUN;
        end else begin
          init_cnt_nxt = init_cnt + 2'd1;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Classify the (prev, cur) phase pair into a +1/-1/0 step or an illegal jump
  always_comb begin
    step = 2'sd0;
    bad  = 1'b0;
    if (state == ST_RUN) begin
      case ({prev, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = 2'sd1;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step = -2'sd1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: bad  = 1'b1;
        default: step = 2'sd0;
      endcase
    end
  end

  // Sign-extend the step and form the saturated accumulator value for this cycle
  always_comb begin
    step_pos = {{(POS_W-2){step[1]}}, step};
    step_vel = {{(VEL_W-1){step[1]}}, step};
    acc_sum  = {acc[VEL_W-1], acc} + step_vel;
    if (acc_sum > VEL_MAX) begin
      acc_sat = VEL_MAX[VEL_W-1:0];
    end else if (acc_sum < VEL_MIN) begin
      acc_sat = VEL_MIN[VEL_W-1:0];
    end else begin
      acc_sat = acc_sum[VEL_W-1:0];
    end
  end

  // Position, direction and sticky error; a clear discards the step, a new error beats a clear
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oPOSITION <= '0;
      oDIR      <= 1'b0;
      oERR      <= 1'b0;
    end else begin
      if (iPOS_CLR) begin
        oPOSITION <= '0;
      end else begin
        oPOSITION <= oPOSITION + step_pos;
      end
      if (step != 2'sd0) begin
        oDIR <= ~step[1];
      end
      if (bad) begin
        oERR <= 1'b1;
      end else if (iERR_CLR) begin
        oERR <= 1'b0;
      end
    end
  end

  // Speed window: the closing cycle's step goes into the published speed, and the accumulator restarts at zero
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      win_cnt      <= '0;
      acc          <= '0;
      oSPEED       <= '0;
      oSPEED_VALID <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt      <= '0;
      acc          <= '0;
      oSPEED       <= acc_sat;
      oSPEED_VALID <= 1'b1;
    end else begin
      win_cnt      <= win_cnt + WIN_W'(1);
      acc          <= acc_sat;
      oSPEED_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed bench for quad_decoder. Two instances share the
// phase inputs: a wide one (32-bit position, 16-bit speed, 10-cycle window)
// and a narrow one (4-bit position, 4-bit speed, 20-cycle window) used to
// exercise wrap-around and saturation. A phase-index model is stepped on every
// rising edge and compared against both instances on every falling edge.
module tb_quad_decoder;

  logic        iCLK     = 1'b0;
  logic        iRST_N   = 1'b0;
  logic        iDATA_A  = 1'b1;
  logic        iDATA_B  = 1'b1;
  logic        iPOS_CLR = 1'b0;
  logic        iERR_CLR = 1'b0;

  logic [31:0] bigPos;
  logic [15:0] bigSpeed;
  logic        bigValid;
  logic        bigDir;
  logic        bigErr;
  logic [3:0]  smallPos;
  logic [3:0]  smallSpeed;
  logic        smallValid;
  logic        smallDir;
  logic        smallErr;

  int          nCompared   = 0;
  int          nMismatched = 0;
  int          speedSumBig = 0;

  // Model state: index 0 is the wide instance, index 1 the narrow one
  int          mEdges;
  logic [1:0]  mHist0;
  logic [1:0]  mHist1;
  logic [1:0]  mHist2;
  longint      mPos   [2];
  int          mAcc   [2];
  int          mSpeed [2];
  int          mWin   [2];
  bit          mValid [2];
  bit          mDir   [2];
  bit          mErr   [2];

  logic [1:0]  fwdSeq [4];
  logic [1:0]  revSeq [4];

  quad_decoder #(.CLK_Freq(1000), .SAMPLE_Freq(100), .POS_W(32), .VEL_W(16)) dutBig (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDATA_A(iDATA_A), .iDATA_B(iDATA_B),
    .iPOS_CLR(iPOS_CLR), .iERR_CLR(iERR_CLR),
    .oPOSITION(bigPos), .oSPEED(bigSpeed), .oSPEED_VALID(bigValid),
    .oDIR(bigDir), .oERR(bigErr)
  );

  quad_decoder #(.CLK_Freq(2000), .SAMPLE_Freq(100), .POS_W(4), .VEL_W(4)) dutSmall (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDATA_A(iDATA_A), .iDATA_B(iDATA_B),
    .iPOS_CLR(iPOS_CLR), .iERR_CLR(iERR_CLR),
    .oPOSITION(smallPos), .oSPEED(smallSpeed), .oSPEED_VALID(smallValid),
    .oDIR(smallDir), .oERR(smallErr)
  );

  always #5 iCLK = ~iCLK;

  // Position of a phase pair {A,B} along the forward cycle 00,10,11,01
  function automatic int phaseOf(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int winLen(input int i);
    return (i == 0) ? 10 : 20;
  endfunction

  function automatic int clampVel(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic modelReset();
    mEdges = 0;
    mHist0 = 2'b00;
    mHist1 = 2'b00;
    mHist2 = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mPos[1'(i)]   = 0;
      mAcc[1'(i)]   = 0;
      mSpeed[1'(i)] = 0;
      mWin[1'(i)]   = 0;
      mValid[1'(i)] = 1'b0;
      mDir[1'(i)]   = 1'b0;
      mErr[1'(i)]   = 1'b0;
    end
  endtask

  // One rising edge of the model: an input change counts three edges after it is first sampled
  task automatic modelStep();
    int delta;
    int stepV;
    bit badV;
    if (!iRST_N) begin
      modelReset();
    end else begin
      if (mEdges < 1000) mEdges = mEdges + 1;
      stepV = 0;
      badV  = 1'b0;
      if (mEdges >= 4) begin
        delta = (phaseOf(mHist1) - phaseOf(mHist2) + 4) % 4;
        if (delta == 1) stepV = 1;
        else if (delta == 3) stepV = -1;
        else if (delta == 2) badV = 1'b1;
      end
      mHist2 = mHist1;
      mHist1 = mHist0;
      mHist0 = {iDATA_A, iDATA_B};
      for (int i = 0; i < 2; i++) begin
        if (iPOS_CLR) mPos[1'(i)] = 0;
        else mPos[1'(i)] = mPos[1'(i)] + stepV;
        if (stepV != 0) mDir[1'(i)] = (stepV > 0);
        if (badV) mErr[1'(i)] = 1'b1;
        else if (iERR_CLR) mErr[1'(i)] = 1'b0;
        mValid[1'(i)] = (mWin[1'(i)] == winLen(i) - 1);
        if (mValid[1'(i)]) begin
          mSpeed[1'(i)] = clampVel(mAcc[1'(i)] + stepV, (i == 0) ? 16 : 4);
          mAcc[1'(i)]   = 0;
        end else begin
          mAcc[1'(i)] = clampVel(mAcc[1'(i)] + stepV, (i == 0) ? 16 : 4);
        end
        mWin[1'(i)] = (mWin[1'(i)] + 1) % winLen(i);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared = nCompared + 1;
    if (act !== exp) begin
      nMismatched = nMismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    logic [63:0] p0;
    logic [63:0] p1;
    p0 = mPos[0];
    p1 = mPos[1];
    checkOutput("big_position",   bigPos,             p0[31:0]);
    checkOutput("big_speed",      32'(bigSpeed),      32'(mSpeed[0]) & 32'h0000FFFF);
    checkOutput("big_valid",      32'(bigValid),      32'(mValid[0]));
    checkOutput("big_dir",        32'(bigDir),        32'(mDir[0]));
    checkOutput("big_err",        32'(bigErr),        32'(mErr[0]));
    checkOutput("small_position", 32'(smallPos),      {28'd0, p1[3:0]});
    checkOutput("small_speed",    32'(smallSpeed),    32'(mSpeed[1]) & 32'h0000000F);
    checkOutput("small_valid",    32'(smallValid),    32'(mValid[1]));
    checkOutput("small_dir",      32'(smallDir),      32'(mDir[1]));
    checkOutput("small_err",      32'(smallErr),      32'(mErr[1]));
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge
  task automatic tick();
    @(posedge iCLK);
    modelStep();
    @(negedge iCLK);
    compareModel();
    if (bigValid) speedSumBig = speedSumBig + int'($signed(bigSpeed));
  endtask

  task automatic applyStimulus(input logic [1:0] ab);
    iDATA_A = ab[1];
    iDATA_B = ab[0];
  endtask

  task automatic waitValid(input bit useSmall, input int limit);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      tick();
      n    = n + 1;
      seen = useSmall ? smallValid : bigValid;
    end
    if (!seen) begin
      nCompared   = nCompared + 1;
      nMismatched = nMismatched + 1;
      $display("[TB] FAIL wait_valid: got no strobe expected one within %0d cycles", limit);
    end
  endtask

  initial begin
    int n;
    fwdSeq[0] = 2'b01; fwdSeq[1] = 2'b00; fwdSeq[2] = 2'b10; fwdSeq[3] = 2'b11;
    revSeq[0] = 2'b01; revSeq[1] = 2'b11; revSeq[2] = 2'b10; revSeq[3] = 2'b00;
    modelReset();

    // Reset with both phases high, release and hold
    $display("[TB] reset and idle with A=B=1");
    applyStimulus(2'b11);
    repeat (3) tick();
    iRST_N = 1'b1;
    repeat (12) tick();
    checkOutput("idle_position", bigPos, 32'd0);
    checkOutput("idle_err", 32'(bigErr), 32'd0);
    checkOutput("idle_dir", 32'(bigDir), 32'd0);

    // Eight forward edges, one every four clocks
    $display("[TB] forward run");
    for (int e = 0; e < 8; e++) begin
      applyStimulus(fwdSeq[2'(e % 4)]);
      repeat (4) tick();
    end
    repeat (12) tick();
    checkOutput("fwd_position", bigPos, 32'd8);
    checkOutput("fwd_dir", 32'(bigDir), 32'd1);
    checkOutput("fwd_speed_sum", 32'(speedSumBig), 32'd8);

    // Move to 00, clear position, then five reverse edges
    $display("[TB] reverse run");
    applyStimulus(2'b01);
    repeat (4) tick();
    applyStimulus(2'b00);
    repeat (4) tick();
    iPOS_CLR = 1'b1;
    tick();
    iPOS_CLR = 1'b0;
    tick();
    checkOutput("clr_position", bigPos, 32'd0);
    waitValid(1'b0, 20);
    speedSumBig = 0;
    for (int e = 0; e < 5; e++) begin
      applyStimulus(revSeq[2'(e % 4)]);
      repeat (4) tick();
    end
    repeat (12) tick();
    checkOutput("rev_position", bigPos, 32'hFFFFFFFB);
    checkOutput("rev_dir", 32'(bigDir), 32'd0);
    checkOutput("rev_speed_sum", 32'(speedSumBig), 32'hFFFFFFFB);
    waitValid(1'b0, 20);
    n = 0;
    do begin
      tick();
      n = n + 1;
    end while (!bigValid && n < 20);
    checkOutput("valid_period", 32'(n), 32'd10);

    // Illegal double-phase jumps and error clearing
    $display("[TB] illegal transitions");
    applyStimulus(2'b00);
    repeat (4) tick();
    applyStimulus(2'b11);
    repeat (4) tick();
    checkOutput("err_set", 32'(bigErr), 32'd1);
    checkOutput("err_position", bigPos, 32'hFFFFFFFC);
    iERR_CLR = 1'b1;
    tick();
    iERR_CLR = 1'b0;
    tick();
    checkOutput("err_clear", 32'(bigErr), 32'd0);
    applyStimulus(2'b00);
    iERR_CLR = 1'b1;
    repeat (3) tick();
    iERR_CLR = 1'b0;
    tick();
    checkOutput("err_set_wins", 32'(bigErr), 32'd1);
    checkOutput("err_position2", bigPos, 32'hFFFFFFFC);

    // A step landing on the last window cycle belongs to that window only
    $display("[TB] window boundary");
    waitValid(1'b0, 20);
    repeat (7) tick();
    applyStimulus(2'b10);
    waitValid(1'b0, 20);
    checkOutput("edge_in_window", 32'(bigSpeed), 32'd1);
    waitValid(1'b0, 20);
    checkOutput("edge_not_next", 32'(bigSpeed), 32'd0);

    // Position clear coinciding with a step discards the step
    applyStimulus(2'b11);
    repeat (2) tick();
    iPOS_CLR = 1'b1;
    tick();
    iPOS_CLR = 1'b0;
    repeat (3) tick();
    checkOutput("clr_on_step", bigPos, 32'd0);

    // Narrow instance: seven steps to 7, then nine inside one window
    $display("[TB] narrow wrap and saturation");
    for (int e = 0; e < 7; e++) begin
      applyStimulus(fwdSeq[2'(e % 4)]);
      repeat (4) tick();
    end
    repeat (2) tick();
    checkOutput("small_at_7", 32'(smallPos), 32'd7);
    waitValid(1'b1, 30);
    for (int j = 0; j < 9; j++) begin
      if (j == 2) checkOutput("small_wrap_neg8", 32'(smallPos), 32'h8);
      applyStimulus(fwdSeq[2'((7 + j) % 4)]);
      repeat (2) tick();
    end
    waitValid(1'b1, 30);
    checkOutput("small_speed_sat", 32'(smallSpeed), 32'd7);
    checkOutput("small_wrap_zero", 32'(smallPos), 32'd0);

    // Asynchronous reset in the middle of a window
    $display("[TB] mid-window reset");
    repeat (3) tick();
    #2;
    iRST_N = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_big_position", bigPos, 32'd0);
    checkOutput("rst_big_speed", 32'(bigSpeed), 32'd0);
    checkOutput("rst_big_valid", 32'(bigValid), 32'd0);
    checkOutput("rst_big_dir", 32'(bigDir), 32'd0);
    checkOutput("rst_big_err", 32'(bigErr), 32'd0);
    checkOutput("rst_small_position", 32'(smallPos), 32'd0);
    checkOutput("rst_small_speed", 32'(smallSpeed), 32'd0);
    repeat (3) tick();
    iRST_N = 1'b1;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
